// File: rtl/mem_pkg.sv
// Shared definitions for the MEM-stage data-memory access unit:
// RV64 load/store funct3 encodings, FSM state type and access-size decode.
package mem_pkg;

    // Loads; stores reuse 000-011 as SB/SH/SW/SD
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    typedef enum logic [1:0] {IDLE, WAIT, DONE} mem_state_t;

    // log2 of the access size in bytes: 0=byte, 1=half, 2=word, 3=double
    function automatic logic [1:0] accessSizeLog2(input logic [2:0] funct3);
        return funct3[1:0];
    endfunction

endpackage

// File: rtl/load_store_align.sv
// Combinational byte-lane logic: store merge into the addressed doubleword,
// load extraction with sign/zero extension, and misalignment detection.
module load_store_align
    import mem_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [2:0]  offset,
    input  logic [63:0] memWord,
    input  logic [63:0] storeData,
    output logic [63:0] mergedWord,
    output logic [63:0] loadData,
    output logic        misaligned
);

    logic [1:0]  sizeLog2;
    logic [2:0]  lowMask;
    logic [2:0]  alignedOff;
    logic [5:0]  bitShift;
    logic [63:0] laneMask;
    logic [63:0] laneMaskShifted;
    logic [63:0] shiftedWord;

    always_comb begin
        sizeLog2 = accessSizeLog2(funct3);
        case (sizeLog2)
            2'd0:    begin lowMask = 3'b000; laneMask = 64'h0000_0000_0000_00FF; end
            2'd1:    begin lowMask = 3'b001; laneMask = 64'h0000_0000_0000_FFFF; end
            2'd2:    begin lowMask = 3'b011; laneMask = 64'h0000_0000_FFFF_FFFF; end
            default: begin lowMask = 3'b111; laneMask = 64'hFFFF_FFFF_FFFF_FFFF; end
        endcase

        // Offsets are aligned down; a trap build uses misaligned to skip the access
        misaligned      = |(offset & lowMask);
        alignedOff      = offset & ~lowMask;
        bitShift        = {alignedOff, 3'b000};
        laneMaskShifted = laneMask << bitShift;

        mergedWord  = (memWord & ~laneMaskShifted) | ((storeData << bitShift) & laneMaskShifted);
        shiftedWord = memWord >> bitShift;

        case (funct3)
            F3_LB:   loadData = {{56{shiftedWord[7]}},  shiftedWord[7:0]};
            F3_LH:   loadData = {{48{shiftedWord[15]}}, shiftedWord[15:0]};
            F3_LW:   loadData = {{32{shiftedWord[31]}}, shiftedWord[31:0]};
            F3_LBU:  loadData = {56'd0, shiftedWord[7:0]};
            F3_LHU:  loadData = {48'd0, shiftedWord[15:0]};
            F3_LWU:  loadData = {32'd0, shiftedWord[31:0]};
            default: loadData = shiftedWord;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// MEM-stage data-memory access unit: fixed-latency load/store FSM, stall and
// writeback gating, data array. Define MEM_MISALIGN_TRAP_EN to trap misaligned accesses.
module mem_access_stage
    import mem_pkg::*;
#(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic        RegWrite,
    input  logic        MemtoReg,
    input  logic [2:0]  Funct3,
    input  logic [63:0] AluOut_in,
    input  logic [63:0] WriteData_in,
    input  logic [4:0]  Rd_in,
    output logic [63:0] Dataout_Memory,
    output logic [63:0] AluOut,
    output logic [4:0]  Rd_out,
    output logic        RegWrite_Out,
    output logic        MemtoReg_Out,
    output logic        Stall,
    output logic        Misalign
);

    localparam int         IDX_W    = $clog2(DEPTH);
    localparam logic [3:0] CNT_INIT = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

    mem_state_t        state;
    logic [3:0]        cnt;
    logic [63:0]       memArray [DEPTH];
    logic [IDX_W-1:0]  wordIdx;
    logic [63:0]       memWord;
    logic [63:0]       mergedWord;
    logic [63:0]       loadData;
    logic              misaligned;
    logic              memOp;
    logic              trap;

    assign wordIdx = AluOut_in[IDX_W+2:3];
    assign memWord = memArray[wordIdx];
    assign memOp   = MemRead | MemWrite;

    load_store_align uAlign (
        .funct3     (Funct3),
        .offset     (AluOut_in[2:0]),
        .memWord    (memWord),
        .storeData  (WriteData_in),
        .mergedWord (mergedWord),
        .loadData   (loadData),
        .misaligned (misaligned)
    );

`ifdef MEM_MISALIGN_TRAP_EN
    assign trap     = memOp & misaligned & (state == IDLE);
    assign Misalign = ~reset & trap;
`else
    logic unusedMisaligned;
    assign unusedMisaligned = misaligned;
    assign trap             = 1'b0;
    assign Misalign         = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (memOp && !trap) begin
                        state <= (LATENCY == 1) ? DONE : WAIT;
                        cnt   <= CNT_INIT;
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) state <= DONE;
                    else             cnt   <= cnt - 4'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Reset forces state out of DONE asynchronously, so an aborted store never commits
    always_ff @(posedge clk) begin
        if (state == DONE && MemWrite) memArray[wordIdx] <= mergedWord;
    end

    assign Stall          = ~reset & (((state == IDLE) & memOp & ~trap) | (state == WAIT));
    assign RegWrite_Out   = ~reset & RegWrite & ~Stall & ~trap;
    assign MemtoReg_Out   = ~reset & MemtoReg;
    assign Dataout_Memory = (~reset && state == DONE && MemRead && !MemWrite) ? loadData : 64'd0;
    assign AluOut         = AluOut_in;
    assign Rd_out         = Rd_in;

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed vector table, reset/misalign sequences,
// and random traffic against a byte-addressed reference memory.
module tb_mem_access_stage;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemRead, MemWrite, RegWrite, MemtoReg;
    logic [2:0]  Funct3;
    logic [63:0] AluOut_in, WriteData_in;
    logic [4:0]  Rd_in;
    logic [63:0] Dataout_Memory, AluOut;
    logic [4:0]  Rd_out;
    logic        RegWrite_Out, MemtoReg_Out, Stall, Misalign;

    int checks = 0;
    int errors = 0;

    logic [7:0] refMem [0:2047];

    typedef struct {
        logic        mr;
        logic        mw;
        logic [2:0]  f3;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    mem_access_stage dut (
        .clk            (clk),
        .reset          (reset),
        .MemRead        (MemRead),
        .MemWrite       (MemWrite),
        .RegWrite       (RegWrite),
        .MemtoReg       (MemtoReg),
        .Funct3         (Funct3),
        .AluOut_in      (AluOut_in),
        .WriteData_in   (WriteData_in),
        .Rd_in          (Rd_in),
        .Dataout_Memory (Dataout_Memory),
        .AluOut         (AluOut),
        .Rd_out         (Rd_out),
        .RegWrite_Out   (RegWrite_Out),
        .MemtoReg_Out   (MemtoReg_Out),
        .Stall          (Stall),
        .Misalign       (Misalign)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference: memory is 2048 bytes, address taken modulo that, offset aligned down to size
    function automatic int refBase(input logic [2:0] f3, input logic [63:0] addr);
        int size = 1 << f3[1:0];
        return int'(addr[10:3]) * 8 + (int'(addr[2:0]) / size) * size;
    endfunction

    function automatic logic [63:0] refLoad(input logic [2:0] f3, input logic [63:0] addr);
        int size = 1 << f3[1:0];
        int base = refBase(f3, addr);
        logic [63:0] v = 64'd0;
        for (int i = 0; i < size; i++) v[8*i +: 8] = refMem[base + i];
        if (!f3[2] && size < 8 && v[8*size-1]) v = v | (~64'd0 << (8 * size));
        return v;
    endfunction

    task automatic refStore(input logic [2:0] f3, input logic [63:0] addr, input logic [63:0] data);
        int size = 1 << f3[1:0];
        int base = refBase(f3, addr);
        for (int i = 0; i < size; i++) refMem[base + i] = data[8*i +: 8];
    endtask

    function automatic vec_t mk(input logic mr, input logic mw, input logic [2:0] f3,
                                input logic [63:0] addr, input logic [63:0] wdata, input logic [63:0] exp);
        vec_t v;
        v.mr = mr; v.mw = mw; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.exp = exp;
        return v;
    endfunction

    task automatic runOp(input string name, input logic mr, input logic mw, input logic [2:0] f3,
                         input logic [63:0] addr, input logic [63:0] wdata, input logic rw,
                         input logic [4:0] rd, input logic [63:0] expData);
        int stalls;
        bit done;
        @(posedge clk); #1;
        MemRead = mr; MemWrite = mw; Funct3 = f3; AluOut_in = addr; WriteData_in = wdata;
        RegWrite = rw; MemtoReg = mr; Rd_in = rd;
        if (!(mr | mw)) begin
            @(negedge clk);
            check({name, " stall"}, 64'(Stall), 64'd0);
            check({name, " data"}, Dataout_Memory, 64'd0);
            check({name, " regwrite"}, 64'(RegWrite_Out), 64'(rw));
            check({name, " aluout"}, AluOut, addr);
            check({name, " rd"}, 64'(Rd_out), 64'(rd));
        end else begin
            stalls = 0;
            done   = 1'b0;
            for (int c = 0; c < 20 && !done; c++) begin
                @(negedge clk);
                if (Stall) begin
                    stalls++;
                    check({name, " rwgate"}, 64'(RegWrite_Out), 64'd0);
                end else begin
                    done = 1'b1;
                end
            end
            if (!done) begin
                checks++;
                errors++;
                $display("FAIL %s timeout stalls=%0d required=%0d", name, stalls, LAT);
            end else begin
                check({name, " stalls"}, 64'(stalls), 64'(LAT));
                check({name, " data"}, Dataout_Memory, expData);
                check({name, " regwrite"}, 64'(RegWrite_Out), 64'(rw));
                check({name, " memtoreg"}, 64'(MemtoReg_Out), 64'(mr));
                check({name, " rd"}, 64'(Rd_out), 64'(rd));
                check({name, " misalign"}, 64'(Misalign), 64'd0);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        MemRead = 1'b1; MemWrite = 1'b0; RegWrite = 1'b1; MemtoReg = 1'b1;
        Funct3 = 3'b011; AluOut_in = 64'h40; WriteData_in = 64'd0; Rd_in = 5'd7;
        for (int i = 0; i < 2048; i++) refMem[i] = 8'h00;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst stall", 64'(Stall), 64'd0);
        check("rst regwrite", 64'(RegWrite_Out), 64'd0);
        check("rst memtoreg", 64'(MemtoReg_Out), 64'd0);
        check("rst data", Dataout_Memory, 64'd0);
        check("rst misalign", 64'(Misalign), 64'd0);
        check("rst aluout", AluOut, 64'h40);
        check("rst rd", 64'(Rd_out), 64'd7);
        MemRead = 1'b0;
        reset   = 1'b0;

        runOp("alu", 1'b0, 1'b0, 3'b000, 64'h1234, 64'd0, 1'b1, 5'd5, 64'd0);

        vecs.push_back(mk(0, 1, 3'b011, 64'h40,   64'hDEADBEEF_CAFEF00D, 64'd0));
        vecs.push_back(mk(1, 0, 3'b011, 64'h40,   64'd0, 64'hDEADBEEF_CAFEF00D));
        vecs.push_back(mk(0, 1, 3'b000, 64'h43,   64'h1234_5680, 64'd0));
        vecs.push_back(mk(1, 0, 3'b000, 64'h43,   64'd0, 64'hFFFFFFFF_FFFFFF80));
        vecs.push_back(mk(1, 0, 3'b100, 64'h43,   64'd0, 64'h80));
        vecs.push_back(mk(1, 0, 3'b011, 64'h40,   64'd0, 64'hDEADBEEF_80FEF00D));
        vecs.push_back(mk(1, 0, 3'b001, 64'h42,   64'd0, 64'hFFFFFFFF_FFFF80FE));
        vecs.push_back(mk(1, 0, 3'b101, 64'h42,   64'd0, 64'h80FE));
        vecs.push_back(mk(1, 0, 3'b010, 64'h44,   64'd0, 64'hFFFFFFFF_DEADBEEF));
        vecs.push_back(mk(1, 0, 3'b110, 64'h44,   64'd0, 64'hDEADBEEF));
        vecs.push_back(mk(0, 1, 3'b011, 64'h840,  64'h1, 64'd0));
        vecs.push_back(mk(1, 0, 3'b011, 64'h40,   64'd0, 64'h1));
        vecs.push_back(mk(0, 1, 3'b001, 64'h46,   64'hABCD, 64'd0));
        vecs.push_back(mk(1, 0, 3'b011, 64'h40,   64'd0, 64'hABCD0000_00000001));
        vecs.push_back(mk(0, 1, 3'b011, 64'h48,   64'h01234567_89ABCDEF, 64'd0));
        vecs.push_back(mk(1, 1, 3'b010, 64'h4C,   64'h55AA55AA, 64'd0));
        vecs.push_back(mk(1, 0, 3'b011, 64'h48,   64'd0, 64'h55AA55AA_89ABCDEF));
        vecs.push_back(mk(1, 0, 3'b011, 64'h1048, 64'd0, 64'h55AA55AA_89ABCDEF));

        foreach (vecs[i]) begin
            runOp($sformatf("vec%0d", i), vecs[i].mr, vecs[i].mw, vecs[i].f3, vecs[i].addr,
                  vecs[i].wdata, vecs[i].mr & ~vecs[i].mw, 5'(i), vecs[i].exp);
            if (vecs[i].mw) refStore(vecs[i].f3, vecs[i].addr, vecs[i].wdata);
        end

        // Store aborted by reset during WAIT must not reach the array
        @(posedge clk); #1;
        MemRead = 1'b0; MemWrite = 1'b1; Funct3 = 3'b011; AluOut_in = 64'h48;
        WriteData_in = 64'h5555; RegWrite = 1'b1; MemtoReg = 1'b1; Rd_in = 5'd9;
        @(negedge clk);
        check("abort present stall", 64'(Stall), 64'd1);
        @(posedge clk); #1;
        check("abort wait stall", 64'(Stall), 64'd1);
        reset = 1'b1;
        #1;
        check("abort stall", 64'(Stall), 64'd0);
        check("abort regwrite", 64'(RegWrite_Out), 64'd0);
        check("abort memtoreg", 64'(MemtoReg_Out), 64'd0);
        check("abort data", Dataout_Memory, 64'd0);
        check("abort aluout", AluOut, 64'h48);
        MemWrite = 1'b0; MemtoReg = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        runOp("abort readback", 1'b1, 1'b0, 3'b011, 64'h48, 64'd0, 1'b1, 5'd10, refLoad(3'b011, 64'h48));
        check("abort model", refLoad(3'b011, 64'h48), 64'h55AA55AA_89ABCDEF);

        runOp("mis setup", 1'b0, 1'b1, 3'b010, 64'h40, 64'h80000001, 1'b0, 5'd0, 64'd0);
        refStore(3'b010, 64'h40, 64'h80000001);
`ifdef MEM_MISALIGN_TRAP_EN
        @(posedge clk); #1;
        MemRead = 1'b1; MemWrite = 1'b0; Funct3 = 3'b010; AluOut_in = 64'h42;
        RegWrite = 1'b1; MemtoReg = 1'b1; Rd_in = 5'd11;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check("mis flag", 64'(Misalign), 64'd1);
            check("mis stall", 64'(Stall), 64'd0);
            check("mis regwrite", 64'(RegWrite_Out), 64'd0);
            check("mis data", Dataout_Memory, 64'd0);
        end
`else
        runOp("mis lw", 1'b1, 1'b0, 3'b010, 64'h42, 64'd0, 1'b1, 5'd11, 64'hFFFFFFFF_80000001);
`endif

        // Random traffic over doublewords 0..31 with random upper address bits
        for (int i = 0; i < 32; i++) begin
            logic [63:0] d;
            d = {$urandom, $urandom};
            runOp("fill", 1'b0, 1'b1, 3'b011, 64'(i * 8), d, 1'b0, 5'd0, 64'd0);
            refStore(3'b011, 64'(i * 8), d);
        end
        for (int n = 0; n < 200; n++) begin
            int kind;
            logic [2:0]  f3;
            logic [2:0]  off;
            logic [63:0] hi, addr, wd, exp;
            logic        mr, mw, rw;
            kind = $urandom_range(0, 3);
            mr   = (kind == 1) || (kind == 3);
            mw   = (kind >= 2);
            f3   = mw ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 6));
            off  = 3'($urandom_range(0, 7));
`ifdef MEM_MISALIGN_TRAP_EN
            off  = off & ~3'((1 << f3[1:0]) - 1);
`endif
            hi   = {$urandom, $urandom};
            addr = {hi[63:11], 3'b000, 5'($urandom_range(0, 31)), off};
            wd   = {$urandom, $urandom};
            rw   = 1'($urandom_range(0, 1));
            exp  = (mr && !mw) ? refLoad(f3, addr) : 64'd0;
            runOp($sformatf("rnd%0d", n), mr, mw, f3, addr, wd, rw, 5'($urandom_range(0, 31)), exp);
            if (mw) refStore(f3, addr, wd);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
